// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: decode/execute redirect requests in, fetch address and
// squash/stack status out. The master side is the surrounding pipeline,
// the slave side is the fetch PC unit.
interface fetch_pc_unit_if #(
  parameter int RAS_DEPTH = 8
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic          stall;
  logic [1:0]    dec_op;
  logic [15:0]   dec_target;
  logic [15:0]   dec_pc_plus1;
  logic          ex_branch;
  logic [15:0]   ex_target;
  logic [15:0]   address;
  logic          kill;
  logic          flush_id;
  logic [CW-1:0] ras_count;
  logic          ras_overflow;
  logic          ras_underflow;

  modport master (
    output stall, dec_op, dec_target, dec_pc_plus1, ex_branch, ex_target,
    input  address, kill, flush_id, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, dec_op, dec_target, dec_pc_plus1, ex_branch, ex_target,
    output address, kill, flush_id, ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch redirect: picks the next fetch address from
// execute branches, decode jump/call/return and sequential increment, keeps
// a circular return-address stack, and produces registered kill/flush_id.
module fetch_pc_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          RAS_DEPTH = 8
) (
  input logic           clk,
  input logic           reset,
  fetch_pc_unit_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  logic [15:0]   addr_q;
  logic          kill_q;
  logic          flush_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] sp_q;      // next free slot; sp_q-1 is top of stack
  logic          ovf_q;
  logic          unf_q;
  logic [15:0]   stack [RAS_DEPTH];

  logic [PW-1:0] sp_top;
  logic [15:0]   next_addr;
  logic          redirect;
  logic          branch;
  logic          push;
  logic          pop;
  logic          underflow;

  assign sp_top = sp_q - PW'(1);

  // Next-PC select: branch beats stall, stall beats any decode request.
  always_comb begin
    next_addr = addr_q + 16'd1;
    redirect  = 1'b0;
    branch    = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    underflow = 1'b0;
    if (bus.ex_branch) begin
      next_addr = bus.ex_target;
      redirect  = 1'b1;
      branch    = 1'b1;
    end else if (bus.stall) begin
      next_addr = addr_q;
    end else begin
      case (bus.dec_op)
        OP_JUMP: begin
          next_addr = bus.dec_target;
          redirect  = 1'b1;
        end
        OP_CALL: begin
          next_addr = bus.dec_target;
          redirect  = 1'b1;
          push      = 1'b1;
        end
        OP_RET: begin
          redirect = 1'b1;
          if (count_q != '0) begin
            next_addr = stack[sp_top];
            pop       = 1'b1;
          end else begin
            // Empty stack: restart from the reset vector and flag it.
            next_addr = RESET_PC;
            underflow = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // PC, squash pulses, stack pointer/count and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= RESET_PC;
      kill_q  <= 1'b0;
      flush_q <= 1'b0;
      count_q <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      addr_q  <= next_addr;
      kill_q  <= redirect;
      flush_q <= branch;
      if (push) begin
        // When full, sp_q already points at the oldest entry, so the
        // write below overwrites it and count saturates.
        sp_q <= sp_q + PW'(1);
        if (count_q == FULL) ovf_q   <= 1'b1;
        else                 count_q <= count_q + CW'(1);
      end
      if (pop) begin
        sp_q    <= sp_top;
        count_q <= count_q - CW'(1);
      end
      if (underflow) unf_q <= 1'b1;
    end
  end

  // Stack storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push && !reset) stack[sp_q] <= bus.dec_pc_plus1;
  end

  assign bus.address       = addr_q;
  assign bus.kill          = kill_q;
  assign bus.flush_id      = flush_q;
  assign bus.ras_count     = count_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, jump, call/return,
// stall vs. branch priority, stack overflow/underflow, wrap and reset.
module tb_fetch_pc_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;

  fetch_pc_unit_if #(.RAS_DEPTH(8)) bus ();

  fetch_pc_unit #(.RESET_PC(16'h0000), .RAS_DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall        = 1'b0;
    bus.dec_op       = 2'b00;
    bus.dec_target   = 16'h0000;
    bus.dec_pc_plus1 = 16'h0000;
    bus.ex_branch    = 1'b0;
    bus.ex_target    = 16'h0000;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    tests++;
    if (bus.address !== 16'h0000 || bus.kill !== 1'b0 || bus.flush_id !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: addr=%h kill=%b flush=%b, want 0000/0/0", bus.address, bus.kill, bus.flush_id);
    end
    tests++;
    if (bus.ras_count !== 4'd0 || bus.ras_overflow !== 1'b0 || bus.ras_underflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_stack: cnt=%0d ovf=%b unf=%b, want 0/0/0", bus.ras_count, bus.ras_overflow, bus.ras_underflow);
    end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [15:0] exp_a;
    for (int i = 1; i <= 4; i++) begin
      tick();
      exp_a = 16'(i);
      tests++;
      if (bus.address !== exp_a || bus.kill !== 1'b0) begin
        fails++;
        $display("FAIL seq_%0d: addr=%h kill=%b, want %h/0", i, bus.address, bus.kill, exp_a);
      end
    end
  endtask

  task automatic test_jump();
    tick();  // address 5
    tests++;
    if (bus.address !== 16'h0005) begin
      fails++;
      $display("FAIL jump_pre: addr=%h, want 0005", bus.address);
    end
    bus.dec_op = 2'b01; bus.dec_target = 16'h000A;
    tick();
    idle_inputs();
    tests++;
    if (bus.address !== 16'h000A || bus.kill !== 1'b1) begin
      fails++;
      $display("FAIL jump_target: addr=%h kill=%b, want 000a/1", bus.address, bus.kill);
    end
    tick();
    tests++;
    if (bus.address !== 16'h000B || bus.kill !== 1'b0) begin
      fails++;
      $display("FAIL jump_after: addr=%h kill=%b, want 000b/0", bus.address, bus.kill);
    end
  endtask

  task automatic test_call_return();
    bus.dec_op = 2'b01; bus.dec_target = 16'h0010;
    tick();
    idle_inputs();
    bus.dec_op = 2'b10; bus.dec_target = 16'h0040; bus.dec_pc_plus1 = 16'h0011;
    tick();
    idle_inputs();
    tests++;
    if (bus.address !== 16'h0040 || bus.kill !== 1'b1 || bus.ras_count !== 4'd1) begin
      fails++;
      $display("FAIL call: addr=%h kill=%b cnt=%0d, want 0040/1/1", bus.address, bus.kill, bus.ras_count);
    end
    tick();
    tests++;
    if (bus.address !== 16'h0041 || bus.kill !== 1'b0) begin
      fails++;
      $display("FAIL call_seq: addr=%h kill=%b, want 0041/0", bus.address, bus.kill);
    end
    tick();  // 0x42
    bus.dec_op = 2'b11;
    tick();
    idle_inputs();
    tests++;
    if (bus.address !== 16'h0011 || bus.kill !== 1'b1 || bus.ras_count !== 4'd0) begin
      fails++;
      $display("FAIL return: addr=%h kill=%b cnt=%0d, want 0011/1/0", bus.address, bus.kill, bus.ras_count);
    end
    tick();
    tests++;
    if (bus.address !== 16'h0012 || bus.kill !== 1'b0 || bus.ras_underflow !== 1'b0) begin
      fails++;
      $display("FAIL return_seq: addr=%h kill=%b unf=%b, want 0012/0/0", bus.address, bus.kill, bus.ras_underflow);
    end
  endtask

  task automatic test_stall_branch();
    bus.stall = 1'b1; bus.dec_op = 2'b01; bus.dec_target = 16'h0099;
    tick();
    tests++;
    if (bus.address !== 16'h0012 || bus.kill !== 1'b0) begin
      fails++;
      $display("FAIL stall_hold: addr=%h kill=%b, want 0012/0", bus.address, bus.kill);
    end
    bus.ex_branch = 1'b1; bus.ex_target = 16'h0080;
    bus.dec_op = 2'b10; bus.dec_pc_plus1 = 16'h5555;  // squashed call: no push
    tick();
    idle_inputs();
    tests++;
    if (bus.address !== 16'h0080 || bus.kill !== 1'b1 || bus.flush_id !== 1'b1 || bus.ras_count !== 4'd0) begin
      fails++;
      $display("FAIL branch: addr=%h kill=%b flush=%b cnt=%0d, want 0080/1/1/0", bus.address, bus.kill, bus.flush_id, bus.ras_count);
    end
    tick();
    tests++;
    if (bus.address !== 16'h0081 || bus.kill !== 1'b0 || bus.flush_id !== 1'b0) begin
      fails++;
      $display("FAIL branch_after: addr=%h kill=%b flush=%b, want 0081/0/0", bus.address, bus.kill, bus.flush_id);
    end
  endtask

  task automatic test_overflow_underflow();
    logic [3:0]  exp_c;
    logic [15:0] exp_a;
    for (int i = 0; i < 9; i++) begin
      bus.dec_op = 2'b10;
      bus.dec_target = 16'h0100 + 16'(i);
      bus.dec_pc_plus1 = 16'h0200 + 16'(i);
      tick();
      exp_c = (i < 7) ? 4'(i + 1) : 4'd8;
      tests++;
      if (bus.address !== 16'h0100 + 16'(i) || bus.kill !== 1'b1 || bus.ras_count !== exp_c) begin
        fails++;
        $display("FAIL push_%0d: addr=%h kill=%b cnt=%0d, want %h/1/%0d", i, bus.address, bus.kill, bus.ras_count, 16'h0100 + 16'(i), exp_c);
      end
    end
    tests++;
    if (bus.ras_overflow !== 1'b1 || bus.ras_underflow !== 1'b0) begin
      fails++;
      $display("FAIL overflow_flag: ovf=%b unf=%b, want 1/0", bus.ras_overflow, bus.ras_underflow);
    end
    bus.dec_op = 2'b11;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_a = 16'h0208 - 16'(i);
      exp_c = 4'(7 - i);
      tests++;
      if (bus.address !== exp_a || bus.kill !== 1'b1 || bus.ras_count !== exp_c || bus.ras_underflow !== 1'b0) begin
        fails++;
        $display("FAIL pop_%0d: addr=%h kill=%b cnt=%0d unf=%b, want %h/1/%0d/0", i, bus.address, bus.kill, bus.ras_count, bus.ras_underflow, exp_a, exp_c);
      end
    end
    tick();
    idle_inputs();
    tests++;
    if (bus.address !== 16'h0000 || bus.kill !== 1'b1 || bus.ras_count !== 4'd0 || bus.ras_underflow !== 1'b1 || bus.ras_overflow !== 1'b1) begin
      fails++;
      $display("FAIL underflow: addr=%h kill=%b cnt=%0d unf=%b ovf=%b, want 0000/1/0/1/1", bus.address, bus.kill, bus.ras_count, bus.ras_underflow, bus.ras_overflow);
    end
  endtask

  task automatic test_wrap();
    bus.dec_op = 2'b01; bus.dec_target = 16'hFFFF;
    tick();
    idle_inputs();
    tests++;
    if (bus.address !== 16'hFFFF) begin
      fails++;
      $display("FAIL wrap_pre: addr=%h, want ffff", bus.address);
    end
    tick();
    tests++;
    if (bus.address !== 16'h0000 || bus.kill !== 1'b0) begin
      fails++;
      $display("FAIL wrap: addr=%h kill=%b, want 0000/0", bus.address, bus.kill);
    end
  endtask

  task automatic test_reset_mid();
    bus.dec_op = 2'b10; bus.dec_target = 16'h0300; bus.dec_pc_plus1 = 16'h0301;
    tick();
    tick();
    tests++;
    if (bus.ras_count !== 4'd2) begin
      fails++;
      $display("FAIL mid_count: cnt=%0d, want 2", bus.ras_count);
    end
    bus.dec_op = 2'b01; bus.dec_target = 16'h0444;  // pending redirect discarded
    reset = 1'b1;
    tick();
    idle_inputs();
    tests++;
    if (bus.address !== 16'h0000 || bus.kill !== 1'b0 || bus.ras_count !== 4'd0 ||
        bus.ras_overflow !== 1'b0 || bus.ras_underflow !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: addr=%h kill=%b cnt=%0d ovf=%b unf=%b, want 0000/0/0/0/0", bus.address, bus.kill, bus.ras_count, bus.ras_overflow, bus.ras_underflow);
    end
    reset = 1'b0;
    bus.dec_op = 2'b11;  // stack is empty again: must underflow
    tick();
    idle_inputs();
    tests++;
    if (bus.address !== 16'h0000 || bus.kill !== 1'b1 || bus.ras_underflow !== 1'b1 || bus.ras_count !== 4'd0) begin
      fails++;
      $display("FAIL post_reset_ret: addr=%h kill=%b unf=%b cnt=%0d, want 0000/1/1/0", bus.address, bus.kill, bus.ras_underflow, bus.ras_count);
    end
    tick();
    tests++;
    if (bus.address !== 16'h0001 || bus.kill !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_seq: addr=%h kill=%b, want 0001/0", bus.address, bus.kill);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_call_return();
    test_stall_branch();
    test_overflow_underflow();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter and fetch-redirect stage sitting directly upstream of the instruction memory. Each cycle it presents a 16-bit word address to the instruction memory, whose registered instruction output appears one cycle later. It selects the next PC from sequential increment, decode-stage jump/call/return, and execute-stage branch redirects. It keeps a small return-address stack and generates the `kill` and `flush_id` pulses that squash wrong-path instructions.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, address presented after reset.
- `RAS_DEPTH`, 8, return-address stack entries (power of two, 2..16).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard freeze of IF/ID. It also drives the instruction memory `stall` input.
- `dec_op`  in  2  decode request:
  - 00 none
  - 01 jump
  - 10 call
  - 11 return
- `dec_target`  in  16  jump/call target from decode.
- `dec_pc_plus1`  in  16  address following the decoded call; this is the value pushed.
- `ex_branch`  in  1  taken branch resolved in execute.
- `ex_target`  in  16  branch target.
- `address`  out  16  current fetch address (registered).
- `kill`  out  1  the instruction-memory output this cycle is wrong-path; IF/ID must load a bubble.
- `flush_id`  out  1  the instruction leaving decode this cycle is squashed; ID/EX must load a bubble.
- `ras_count`  out  $clog2(RAS_DEPTH)+1  valid stack entries.
- `ras_overflow`  out  1  sticky; set when a call pushes onto a full stack.
- `ras_underflow`  out  1  sticky; set when a return pops an empty stack.

## Operation
- The address is word-granular; sequential next PC = `address + 1`, modulo 2^16 (16'hFFFF wraps to 16'h0000).
- Next-PC priority, highest first:
  1. `ex_branch`: next = `ex_target`. This overrides `stall` and ignores `dec_op`, because the decode instruction is younger and squashed. No stack push/pop occurs.
  2. `stall`: `address` holds. `dec_op` is ignored; decode re-presents the request after the stall.
  3. `dec_op`=jump: next = `dec_target`.
  4. `dec_op`=call: next = `dec_target`; push `dec_pc_plus1`.
  5. `dec_op`=return:
     - stack non-empty: next = top of stack; pop.
     - stack empty: next = `RESET_PC`, set `ras_underflow`, count stays 0.
  6. Otherwise next = `address + 1`.
- Stack is a circular buffer with a top pointer.
  - Push when full: overwrite the oldest entry, set `ras_overflow`, `ras_count` stays `RAS_DEPTH`.
  - Pop after an overflow returns the newest entries correctly; the oldest is lost.
- `kill` is registered. It is 1 in the cycle after any accepted redirect (branch, jump, call, or return, including a return that underflows); otherwise 0.
- `flush_id` is registered. It is 1 in the cycle after an accepted `ex_branch`; otherwise 0.
- Reset values:
  - `address` = `RESET_PC`
  - `kill` = 0, `flush_id` = 0
  - `ras_count` = 0, stack pointer = 0
  - both sticky flags = 0
  - Stack contents are don't-care.
- Reset asserted mid-operation discards any pending redirect and clears the stack, with the same values.

## Timing
- A redirect sampled at edge N gives `address` = target from cycle N+1. The instruction memory returns the target instruction at N+2.
- `kill` high during N+1, marking the memory output fetched from the pre-redirect address.
- A redirect that is not accepted (decode during `stall`) produces no `kill` and no stack change.
- Back-to-back redirects in consecutive cycles each produce their own 1-cycle `kill`; `kill` may remain high continuously.
- A push and its dependent return in the next cycle: the return sees the pushed value. There is no bypass hazard, because the stack updates at the edge.
- No combinational path from any input to any output.

## Test plan
- Reset then 4 free-running cycles, `RESET_PC`=0 -> `address` 0,1,2,3,4; `kill`=0 throughout.
- At `address` 5, `dec_op`=jump, target 16'h000A -> next cycle `address`=000A, `kill`=1 for one cycle, then 000B.
- Call at 0x10 (target 0x40, pc_plus1 0x11), then return at 0x42 -> `address` 0x40, later 0x11; `ras_count` 1 then 0; `kill` pulses after each redirect.
- `stall`=1 with `dec_op`=jump, then `ex_branch`=1 to 0x80 with stall still high -> during the stall the jump is ignored and `address` holds; `address`=0x80 next cycle; `kill`=1 and `flush_id`=1 for one cycle; no stack change.
- Nine calls with `RAS_DEPTH`=8, then nine returns -> `ras_overflow`=1 and `ras_count`=8. The first 8 returns yield the pushed addresses newest-first. The 9th return goes to `RESET_PC` with `ras_underflow`=1.
- `address`=16'hFFFF, no redirect -> wraps to 16'h0000. Reset asserted mid-stack -> `ras_count`=0, flags cleared, `address`=`RESET_PC` next cycle.
